// File: rtl/tc_scan_sched.sv
// tc_scan_sched -- shares one SPI master between up to 8 thermocouple converters.
// After a power-up settling delay the block runs periodic scans. Each scan makes one
// 32-bit read per enabled channel through the spi_ena / spi_not_busy handshake, and
// every frame is presented downstream with its channel index.
//
// Optional feature: define TC_SCHED_TIMEOUT_EN to add a per-channel transaction
// watchdog. If a transfer takes TIMEOUT_CYCLES cycles, counted from REQ entry, the
// block emits a zeroed frame flagged with rx_timeout. Without the macro, REQ and BUSY
// wait indefinitely and rx_timeout stays 0.
module tc_scan_sched #(
  parameter int NUM_CH         = 4,
  parameter int STARTUP_CYCLES = 6000,
  parameter int SCAN_PERIOD    = 2000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              spi_not_busy,
  input  logic [31:0]       spi_rx_data,
  output logic              spi_ena,
  output logic [2:0]        cs_sel,
  output logic              rx_valid,
  output logic [2:0]        rx_ch,
  output logic [31:0]       rx_data,
  output logic              rx_timeout,
  output logic [NUM_CH-1:0] fault_map,
  output logic              scan_done
);

  // One counter width covers the startup delay, the scan period and the watchdog.
  // Every count is compared against its terminal value minus one, so it never wraps.
  localparam int MAX_SU  = (STARTUP_CYCLES > SCAN_PERIOD) ? STARTUP_CYCLES : SCAN_PERIOD;
  localparam int MAX_ALL = (MAX_SU > TIMEOUT_CYCLES) ? MAX_SU : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(SCAN_PERIOD - 1);

  // The pointer has to reach NUM_CH (up to 8), which marks the end of a scan.
  localparam logic [3:0] PTR_END = 4'(NUM_CH);

  typedef enum logic [2:0] {
    S_START,
    S_WAIT,
    S_SEL,
    S_REQ,
    S_BUSY
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ptr;

  logic              sel_en;       // the channel under the pointer is enabled
  logic [NUM_CH-1:0] fault_frame;  // fault_map after a real frame on cs_sel
  logic [NUM_CH-1:0] fault_tmo;    // fault_map after a timeout on cs_sel
  logic              tmo_hit;      // watchdog expires on this edge

`ifdef TC_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Watchdog: held at 0 in SEL (so it is clear on REQ entry), then counts through REQ and BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == S_SEL) begin
      tmo_cnt <= '0;
    end else if ((state == S_REQ || state == S_BUSY) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Decode the pointer against the mask and build both candidate fault_map updates.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel_en      = 1'b0;
    fault_frame = fault_map;
    fault_tmo   = fault_map;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ptr == 4'(i)) begin
        sel_en = ch_mask[i];
      end
      if (cs_sel == 3'(i)) begin
        fault_frame[i] = spi_rx_data[16];
        fault_tmo[i]   = 1'b1;
      end
    end
  end

  // Scan sequencer. All outputs are registered here; rx_valid and scan_done are one-cycle pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    if (rst) begin
      state      <= S_START;
      cnt        <= '0;
      ptr        <= '0;
      spi_ena    <= 1'b0;
      cs_sel     <= '0;
      rx_valid   <= 1'b0;
      rx_ch      <= '0;
      rx_data    <= '0;
      rx_timeout <= 1'b0;
      fault_map  <= '0;
      scan_done  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      scan_done <= 1'b0;

      case (state)
        // Power-up settling delay before the first scan.
        S_START: begin
          if (cnt == STARTUP_LAST) begin
            cnt   <= '0;
            ptr   <= '0;
            state <= S_SEL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Idle gap between scans.
        S_WAIT: begin
          if (cnt == PERIOD_LAST) begin
            cnt   <= '0;
            ptr   <= '0;
            state <= S_SEL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Walk the mask. Each skipped channel costs one cycle.
        S_SEL: begin
          if (ptr == PTR_END) begin
            scan_done <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT;
          end else if (sel_en) begin
            cs_sel  <= ptr[2:0];
            spi_ena <= 1'b1;
            state   <= S_REQ;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end

        // Hold the request until the SPI master reports that it has started.
        S_REQ: begin
          if (tmo_hit) begin
            spi_ena    <= 1'b0;
            rx_valid   <= 1'b1;
            rx_timeout <= 1'b1;
            rx_data    <= '0;
            rx_ch      <= cs_sel;
            fault_map  <= fault_tmo;
            ptr        <= ptr + 1'b1;
            state      <= S_SEL;
          end else if (!spi_not_busy) begin
            spi_ena <= 1'b0;
            state   <= S_BUSY;
          end
        end

        // Wait for the transfer to finish. A real frame beats a simultaneous timeout.
        S_BUSY: begin
          if (spi_not_busy) begin
            rx_valid   <= 1'b1;
            rx_timeout <= 1'b0;
            rx_data    <= spi_rx_data;
            rx_ch      <= cs_sel;
            fault_map  <= fault_frame;
            ptr        <= ptr + 1'b1;
            state      <= S_SEL;
          end else if (tmo_hit) begin
            rx_valid   <= 1'b1;
            rx_timeout <= 1'b1;
            rx_data    <= '0;
            rx_ch      <= cs_sel;
            fault_map  <= fault_tmo;
            ptr        <= ptr + 1'b1;
            state      <= S_SEL;
          end
        end

        default: begin
          state <= S_START;
        end
      endcase
    end
  end

endmodule
